// File: rtl/uart_com_ex.sv
// uart_com_ex: parametrised UART (5..8 data bits, none/odd/even parity, 1/2 stop
// bits) with 16x oversampled majority-vote receiver and a byte FIFO per direction.

// Circular first-word-fall-through FIFO; the extra pointer bit separates full from empty.
module uart_com_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  logic [AW:0]   wp, rp;
  logic [DW-1:0] mem [2**AW];
  logic          wr_ok, rd_ok;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_ok = pop && !empty;
  // a pop frees the slot the push lands in, so a full FIFO still takes both
  assign wr_ok = push && (!full || rd_ok);
  assign rdata = mem[rp[AW-1:0]];

  // pointers and storage; storage cleared so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (rd_ok) rp <= rp + 1'b1;
    end
  end
endmodule

module uart_com_ex #(
  parameter int BAUDRATE       = 9600,
  parameter int CLOCKRATE      = 100000000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_flag,
  input  logic [7:0] send_data,
  input  logic       recv_flag,
  output logic [7:0] recv_data,
  output logic       sendable,
  output logic       receivable,
  output logic       tx_busy,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_overrun,
  input  logic       err_clear,
  input  logic       Rx,
  output logic       Tx
);
  localparam int   DIV_RAW  = CLOCKRATE / (BAUDRATE * 16);
  localparam int   DIVISOR  = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int   BIT_CLKS = 16 * DIVISOR;
  localparam int   CW       = $clog2(BIT_CLKS);
  localparam int   DVW      = $clog2(DIVISOR + 1);
  localparam int   DW       = DATA_BITS;
  localparam logic PAR_ODD  = 1'(PARITY == 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_DONE} rx_state_t;

  // ---------------- TX ----------------
  tx_state_t     tst, tst_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic [2:0]    tidx, tidx_n;
  logic [DW-1:0] tsh, tsh_n, tx_head;
  logic          tpar, tpar_n, tx_pop, tx_full, tx_empty, tx_q, tx_act_q, tx_line;
  logic          tend, load;

  uart_com_fifo #(.DW(DW), .AW(FIFO_DEPTH_LOG)) u_txf (
    .clk(clk), .rst(rst), .push(send_flag & ~tx_full), .wdata(send_data[DW-1:0]),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty));

  assign tend = (tcnt == CW'(BIT_CLKS - 1));

  // TX next state: every bit lasts BIT_CLKS clocks; the last stop bit may chain straight into the next start
  always_comb begin
    tst_n  = tst;
    tcnt_n = tend ? '0 : tcnt + 1'b1;
    tidx_n = tidx;
    tsh_n  = tsh;
    tpar_n = tpar;
    tx_pop = 1'b0;
    load   = 1'b0;
    case (tst)
      T_IDLE: begin
        tcnt_n = '0;
        load   = !tx_empty;
      end
      T_START: if (tend) tst_n = T_DATA;
      T_DATA: if (tend) begin
        tsh_n  = tsh >> 1;
        tidx_n = tidx + 1'b1;
        if (tidx == 3'(DW - 1)) begin
          tidx_n = '0;
          tst_n  = (PARITY != 0) ? T_PAR : T_STOP;
        end
      end
      T_PAR: if (tend) tst_n = T_STOP;
      T_STOP: if (tend) begin
        tidx_n = tidx + 1'b1;
        if (tidx == 3'(STOP_BITS - 1)) begin
          tidx_n = '0;
          tst_n  = T_IDLE;
          load   = !tx_empty;
        end
      end
      default: tst_n = T_IDLE;
    endcase
    if (load) begin
      tst_n  = T_START;
      tcnt_n = '0;
      tidx_n = '0;
      tsh_n  = tx_head;
      tpar_n = (^tx_head) ^ PAR_ODD;
      tx_pop = 1'b1;
    end
  end

  // line level implied by the current TX state
  always_comb begin
    case (tst)
      T_START: tx_line = 1'b0;
      T_DATA:  tx_line = tsh[0];
      T_PAR:   tx_line = tpar;
      default: tx_line = 1'b1;
    endcase
  end

  // TX state register; Tx is registered so it lags the state by one clock and never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tst <= T_IDLE; tcnt <= '0; tidx <= '0; tsh <= '0; tpar <= 1'b0;
      tx_q <= 1'b1; tx_act_q <= 1'b0;
    end else begin
      tst <= tst_n; tcnt <= tcnt_n; tidx <= tidx_n; tsh <= tsh_n; tpar <= tpar_n;
      tx_q <= tx_line; tx_act_q <= (tst != T_IDLE);
    end
  end

  assign Tx       = tx_q;
  assign sendable = !tx_full;
  assign tx_busy  = !tx_empty || (tst != T_IDLE) || tx_act_q;

  // ---------------- RX ----------------
  rx_state_t      rxs, rxs_n;
  logic [DVW-1:0] dcnt;
  logic [3:0]     rcnt, rcnt_n;
  logic [2:0]     ridx, ridx_n;
  logic [DW-1:0]  rsh, rsh_n, rx_head;
  logic [1:0]     samp, samp_n;
  logic           rx_s1, rx_s2, rx_d, tick, mid, rend, vote;
  logic           rpar, rpar_n, rstop, rstop_n, rx_push, rx_full, rx_empty;
  logic           set_par, set_frm, set_ovr;

  uart_com_fifo #(.DW(DW), .AW(FIFO_DEPTH_LOG)) u_rxf (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rsh), .pop(recv_flag),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty));

  assign tick = (dcnt == DVW'(DIVISOR - 1));
  assign mid  = tick && (rcnt == 4'd9);
  assign rend = tick && (rcnt == 4'd15);
  // ticks 7 and 8 are held in samp, tick 9 is the live input
  assign vote = (samp[1] & samp[0]) | (samp[1] & rx_s2) | (samp[0] & rx_s2);

  // free-running oversample tick and Rx synchronizer (plus one stage for edge detect)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt <= '0; rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
    end else begin
      dcnt  <= tick ? '0 : dcnt + 1'b1;
      rx_s1 <= Rx; rx_s2 <= rx_s1; rx_d <= rx_s2;
    end
  end

  // RX next state: 16 ticks per bit, decision at tick 9; stop handled as soon as it is voted
  always_comb begin
    rxs_n = rxs; rcnt_n = rcnt; ridx_n = ridx; rsh_n = rsh;
    rpar_n = rpar; rstop_n = rstop; samp_n = samp;
    rx_push = 1'b0; set_par = 1'b0; set_frm = 1'b0; set_ovr = 1'b0;
    if (tick) rcnt_n = rcnt + 1'b1;
    if (tick && (rcnt == 4'd7 || rcnt == 4'd8)) samp_n = {samp[0], rx_s2};
    case (rxs)
      R_IDLE: begin
        rcnt_n = '0;
        ridx_n = '0;
        if (rx_d && !rx_s2) rxs_n = R_START;
      end
      R_START: if (mid && vote) rxs_n = R_IDLE;
               else if (rend) rxs_n = R_DATA;
      R_DATA: begin
        if (mid) rsh_n = {vote, rsh[DW-1:1]};
        if (rend) begin
          ridx_n = ridx + 1'b1;
          if (ridx == 3'(DW - 1)) begin
            ridx_n = '0;
            rxs_n  = (PARITY != 0) ? R_PAR : R_STOP;
          end
        end
      end
      R_PAR: begin
        if (mid) rpar_n = vote;
        if (rend) rxs_n = R_STOP;
      end
      R_STOP: if (mid) begin
        rstop_n = vote;
        rxs_n   = R_DONE;
      end
      R_DONE: begin
        rxs_n = R_IDLE;
        if (!rstop) set_frm = 1'b1;
        else if (rx_full && !recv_flag) set_ovr = 1'b1;
        else begin
          rx_push = 1'b1;
          set_par = (PARITY != 0) && (((^rsh) ^ rpar) != PAR_ODD);
        end
      end
      default: rxs_n = R_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxs <= R_IDLE; rcnt <= '0; ridx <= '0; rsh <= '0;
      rpar <= 1'b0; rstop <= 1'b1; samp <= 2'b11;
    end else begin
      rxs <= rxs_n; rcnt <= rcnt_n; ridx <= ridx_n; rsh <= rsh_n;
      rpar <= rpar_n; rstop <= rstop_n; samp <= samp_n;
    end
  end

  // sticky errors; a clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_parity <= 1'b0; err_frame <= 1'b0; err_overrun <= 1'b0;
    end else if (err_clear) begin
      err_parity <= 1'b0; err_frame <= 1'b0; err_overrun <= 1'b0;
    end else begin
      err_parity  <= err_parity  | set_par;
      err_frame   <= err_frame   | set_frm;
      err_overrun <= err_overrun | set_ovr;
    end
  end

  assign recv_data  = 8'(rx_head);
  assign receivable = !rx_empty;
endmodule

// File: tb/tb_uart_com_ex.sv
// Bench for uart_com_ex: an 8N1 instance and a 7E2 instance at 16 clk per bit,
// with scoreboard queues for both TX (line monitor) and RX (pop checker).
module tb_uart_com_ex;
  logic clk;
  logic rst8, send_flag8, recv_flag8, err_clear8, rx8;
  logic [7:0] send_data8, recv_data8;
  logic sendable8, receivable8, tx_busy8, err_parity8, err_frame8, err_overrun8, tx8;
  logic rst7, send_flag7, recv_flag7, err_clear7, rx7;
  logic [7:0] send_data7, recv_data7;
  logic sendable7, receivable7, tx_busy7, err_parity7, err_frame7, err_overrun7, tx7;

  int n_chk = 0, n_fail = 0;
  logic [7:0] txq8[$], rxq8[$], rxq7[$];
  time tx_starts[$];

  uart_com_ex #(.BAUDRATE(1000000), .CLOCKRATE(16000000)) u_dut8 (
    .clk(clk), .rst(rst8), .send_flag(send_flag8), .send_data(send_data8),
    .recv_flag(recv_flag8), .recv_data(recv_data8), .sendable(sendable8),
    .receivable(receivable8), .tx_busy(tx_busy8), .err_parity(err_parity8),
    .err_frame(err_frame8), .err_overrun(err_overrun8), .err_clear(err_clear8),
    .Rx(rx8), .Tx(tx8));

  uart_com_ex #(.BAUDRATE(1000000), .CLOCKRATE(16000000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2)) u_dut7 (
    .clk(clk), .rst(rst7), .send_flag(send_flag7), .send_data(send_data7),
    .recv_flag(recv_flag7), .recv_data(recv_data7), .sendable(sendable7),
    .receivable(receivable7), .tx_busy(tx_busy7), .err_parity(err_parity7),
    .err_frame(err_frame7), .err_overrun(err_overrun7), .err_clear(err_clear7),
    .Rx(rx7), .Tx(tx7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input bit s7, input logic v);
    if (s7) rx7 = v; else rx8 = v;
  endtask

  // one frame on Rx, 16 clk per bit; flip inverts the parity bit, stop is the first stop level
  task automatic drive_rx(input bit s7, input logic [7:0] d, input int nb, input int par,
                          input bit flip, input logic stop, input int nstop);
    logic bq[$];
    logic [7:0] m;
    m = 8'((1 << nb) - 1);
    bq.push_back(1'b0);
    for (int i = 0; i < nb; i++) bq.push_back(d[i]);
    if (par != 0) bq.push_back((^(d & m)) ^ (par == 1) ^ flip);
    bq.push_back(stop);
    for (int i = 1; i < nstop; i++) bq.push_back(1'b1);
    foreach (bq[i]) begin
      set_rx(s7, bq[i]);
      repeat (16) @(negedge clk);
    end
    set_rx(s7, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_rx(input bit s7, input string tag);
    logic [7:0] e;
    if (s7) begin
      chk({tag, "_sb"}, rxq7.size() > 0, 1);
      if (rxq7.size() > 0) begin
        e = rxq7.pop_front();
        chk({tag, "_rdy"}, receivable7, 1);
        chk(tag, recv_data7, e);
      end
      recv_flag7 = 1'b1; @(negedge clk); recv_flag7 = 1'b0;
    end else begin
      chk({tag, "_sb"}, rxq8.size() > 0, 1);
      if (rxq8.size() > 0) begin
        e = rxq8.pop_front();
        chk({tag, "_rdy"}, receivable8, 1);
        chk(tag, recv_data8, e);
      end
      recv_flag8 = 1'b1; @(negedge clk); recv_flag8 = 1'b0;
    end
  endtask

  // decodes 8N1 frames on the 8-bit instance's Tx and checks them against txq8
  initial begin : txmon
    logic [7:0] d;
    logic sb;
    forever begin
      @(negedge clk);
      if (tx8 === 1'b0) begin
        tx_starts.push_back($time);
        repeat (8) @(negedge clk);
        chk("tx_startbit", tx8, 0);
        for (int b = 0; b < 8; b++) begin
          repeat (16) @(negedge clk);
          d[b] = tx8;
        end
        repeat (16) @(negedge clk);
        sb = tx8;
        chk("tx_stop", sb, 1);
        chk("tx_sb", txq8.size() > 0, 1);
        if (txq8.size() > 0) chk("tx_byte", d, txq8.pop_front());
        repeat (7) @(negedge clk);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int k, n0;
    rst8 = 0; rst7 = 0;
    send_flag8 = 0; send_data8 = 0; recv_flag8 = 0; err_clear8 = 0; rx8 = 1;
    send_flag7 = 0; send_data7 = 0; recv_flag7 = 0; err_clear7 = 0; rx7 = 1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx8, 1);
    chk("rst_sendable", sendable8, 1);
    chk("rst_recv", receivable8, 0);
    chk("rst_rdata", recv_data8, 0);
    chk("rst_busy", tx_busy8, 0);
    chk("rst_errs", {err_parity8, err_frame8, err_overrun8}, 0);
    rst8 = 1; rst7 = 1;
    repeat (3) @(negedge clk);

    // single 8N1 frame: start edge two clocks after the push, busy ends with the stop bit
    send_flag8 = 1; send_data8 = 8'hA5; txq8.push_back(8'hA5);
    @(negedge clk); send_flag8 = 0;
    chk("tx_lat1", tx8, 1);
    chk("tx_busy_on", tx_busy8, 1);
    @(negedge clk); chk("tx_lat2", tx8, 1);
    @(negedge clk); chk("tx_lat3", tx8, 0);
    repeat (159) @(negedge clk);
    chk("tx_busy_stop", tx_busy8, 1);
    @(negedge clk);
    chk("tx_busy_off", tx_busy8, 0);
    chk("tx_idle", tx8, 1);
    repeat (5) @(negedge clk);

    // 7E2 receive: good parity, then flipped parity (byte kept, error flagged)
    rxq7.push_back(8'h41);
    drive_rx(1, 8'h41, 7, 2, 0, 1, 2);
    chk("p_errpar0", err_parity7, 0);
    chk("p_errfrm0", err_frame7, 0);
    pop_rx(1, "rx7_a");
    chk("rx7_empty", receivable7, 0);
    rxq7.push_back(8'h41);
    drive_rx(1, 8'h41, 7, 2, 1, 1, 2);
    chk("p_errpar1", err_parity7, 1);
    pop_rx(1, "rx7_b");
    err_clear7 = 1; @(negedge clk); err_clear7 = 0;
    chk("p_clr", err_parity7, 0);

    // framing error drops the byte; a short glitch is a false start
    drive_rx(0, 8'h3C, 8, 0, 0, 0, 1);
    chk("frm_none", receivable8, 0);
    chk("frm_err", err_frame8, 1);
    err_clear8 = 1; @(negedge clk); err_clear8 = 0;
    chk("frm_clr", err_frame8, 0);
    rx8 = 0; repeat (4) @(negedge clk); rx8 = 1;
    repeat (40) @(negedge clk);
    chk("glitch_none", receivable8, 0);
    chk("glitch_errs", {err_parity8, err_frame8, err_overrun8}, 0);

    // overrun: ninth byte into a full RX FIFO is dropped
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) rxq8.push_back(b);
      drive_rx(0, b, 8, 0, 0, 1, 1);
      if (i == 7) chk("ovr_err0", err_overrun8, 0);
    end
    chk("ovr_rdy", receivable8, 1);
    chk("ovr_err", err_overrun8, 1);
    for (int i = 0; i < 8; i++) pop_rx(0, "ovr_pop");
    chk("ovr_empty", receivable8, 0);

    // TX burst behind an in-flight frame: 8 fill the FIFO, the 9th is lost
    n0 = tx_starts.size();
    send_flag8 = 1; send_data8 = 8'h5A; txq8.push_back(8'h5A);
    @(negedge clk); send_flag8 = 0;
    repeat (9) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      chk("burst_sendable", sendable8, 32'(i < 8));
      if (i < 8) txq8.push_back(b);
      send_flag8 = 1; send_data8 = b;
      @(negedge clk);
    end
    send_flag8 = 0;
    k = 0;
    while (tx_busy8 && k < 3000) begin @(negedge clk); k++; end
    chk("burst_done", tx_busy8, 0);
    repeat (4) @(negedge clk);
    chk("burst_frames", tx_starts.size() - n0, 9);
    chk("burst_q", txq8.size(), 0);
    for (int i = n0 + 1; i < tx_starts.size(); i++)
      chk("burst_gap", 32'(tx_starts[i] - tx_starts[i-1]), 1600);

    // reset in the middle of a TX frame and an RX frame
    send_flag7 = 1; send_data7 = 8'h00; rx7 = 0;
    @(negedge clk); send_flag7 = 0;
    repeat (40) @(negedge clk);
    chk("mid_tx_low", tx7, 0);
    chk("mid_busy", tx_busy7, 1);
    rst7 = 0; #1;
    chk("arst_tx", tx7, 1);
    chk("arst_busy", tx_busy7, 0);
    chk("arst_sendable", sendable7, 1);
    chk("arst_recv", receivable7, 0);
    rx7 = 1;
    repeat (2) @(negedge clk);
    rst7 = 1;
    repeat (20) @(negedge clk);
    chk("post_rst_tx", tx7, 1);
    chk("post_rst_recv", receivable7, 0);
    rxq7.push_back(8'h2A);
    drive_rx(1, 8'h2A, 7, 2, 0, 1, 2);
    pop_rx(1, "rst_rx");
    chk("rst_rx_err", {err_parity7, err_frame7, err_overrun7}, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
